// File: rtl/trunc_sat_pipe_pkg.sv
// trunc_sat_pipe_pkg: skid state type and a reusable saturating-truncation helper
package trunc_sat_pipe_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;
  localparam int SAT_KW = 64;
  typedef struct packed {
    logic [SAT_KW-1:0] res;
    logic              sat;
  } sat_res_t;
  // k arrives already sign- or zero-extended to SAT_KW; only the low dout bits of res matter
  function automatic sat_res_t sat_trunc(input logic [SAT_KW-1:0] k, input int dout, input bit sgn);
    longint   ks, hi, lo;
    sat_res_t r;
    ks    = longint'(k);
    hi    = sgn ? (longint'(1) <<< (dout - 1)) - 64'sd1 : (longint'(1) <<< dout) - 64'sd1;
    lo    = sgn ? -(longint'(1) <<< (dout - 1)) : 64'sd0;
    r.sat = (ks > hi) || (ks < lo);
    r.res = (ks > hi) ? hi : (ks < lo) ? lo : k;
    return r;
  endfunction
endpackage

// File: rtl/trunc_sat_pipe_skid_buf.sv
// skid_buf: 2-entry valid/ready register slice whose ready and valid are both state decodes
module skid_buf
  import trunc_sat_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);
  skid_state_t r_state, w_next;
  logic [W-1:0] r_main, r_skid;
  logic w_in, w_out, w_load_main, w_load_skid, w_pop_skid;
  assign o_valid = r_state != EMPTY;
  assign o_ready = r_state != TWO;
  assign o_data  = r_main;
  assign w_in    = i_valid & o_ready;
  assign w_out   = o_valid & i_ready;
  // state register
  always_ff @(posedge clk)
    if (!rst) r_state <= EMPTY;
    else r_state <= w_next;
  // next-state: occupancy moves up on input-only, down on output-only
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   w_next = w_in ? ONE : EMPTY;
      ONE:     w_next = (w_in && !w_out) ? TWO : (w_out && !w_in) ? EMPTY : ONE;
      TWO:     w_next = w_out ? ONE : TWO;
      default: w_next = EMPTY;
    endcase
  end
  // datapath steering: new word goes to main unless main is still held, then to skid
  always_comb begin
    w_load_main = w_in && (r_state == EMPTY || w_out);
    w_load_skid = w_in && r_state == ONE && !w_out;
    w_pop_skid  = w_out && r_state == TWO;
  end
  // main and skid data registers
  always_ff @(posedge clk)
    if (!rst) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main) r_main <= i_data;
      else if (w_pop_skid) r_main <= r_skid;
      if (w_load_skid) r_skid <= i_data;
    end
endmodule

// File: rtl/trunc_sat_pipe.sv
// trunc_sat_pipe: drop SHIFT rounded-off bits, saturate to DOUT bits, skid-buffered output with saturation status
module trunc_sat_pipe
  import trunc_sat_pipe_pkg::*;
#(
  parameter int DIN    = 16,
  parameter int SHIFT  = 4,
  parameter int DOUT   = 8,
  parameter int SIGNED = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             din_ready,
  input  logic             din_valid,
  input  logic [DIN-1:0]   din_data,
  input  logic             dout_ready,
  output logic             dout_valid,
  output logic [DOUT-1:0]  dout_data,
  input  logic             clr,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_cnt
);
  localparam int KW = DIN - SHIFT;
  logic              w_ext, w_ev;
  logic [SAT_KW-1:0] w_k;
  sat_res_t          w_sr;
  logic [DOUT:0]     w_out_word;
  logic              r_sat_flag;
  logic [CNT_W-1:0]  r_sat_cnt;
  assign w_ext     = (SIGNED != 0) && din_data[DIN-1];
  assign w_k       = {{(SAT_KW - KW){w_ext}}, din_data[DIN-1:SHIFT]};
  assign w_sr      = sat_trunc(w_k, DOUT, SIGNED != 0);
  assign w_ev      = din_valid & din_ready & w_sr.sat;
  assign dout_data = w_out_word[DOUT-1:0];
  assign sat_flag  = r_sat_flag;
  assign sat_cnt   = r_sat_cnt;
  skid_buf #(.W(DOUT + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (din_valid),
    .o_ready (din_ready),
    .i_data  ({w_sr.sat, w_sr.res[DOUT-1:0]}),
    .o_valid (dout_valid),
    .i_ready (dout_ready),
    .o_data  (w_out_word)
  );
  // status on acceptance: clr wipes history first, then the current event is applied
  always_ff @(posedge clk)
    if (!rst) begin
      r_sat_flag <= 1'b0;
      r_sat_cnt  <= '0;
    end else begin
      r_sat_flag <= (r_sat_flag & ~clr) | w_ev;
      r_sat_cnt  <= clr ? CNT_W'(w_ev) : (w_ev && !(&r_sat_cnt)) ? r_sat_cnt + 1'b1 : r_sat_cnt;
    end
endmodule

// File: tb/tb_trunc_sat_pipe.sv
// tb_trunc_sat_pipe: scoreboard bench driving a signed/16-bit-count and an unsigned/2-bit-count instance in lockstep
module tb_trunc_sat_pipe;
  logic        clk = 0;
  logic        rst = 0;
  logic        din_valid = 0;
  logic [15:0] din_data = '0;
  logic        dout_ready = 1;
  logic        clr = 0;
  logic        din_ready, dout_valid, sat_flag;
  logic [7:0]  dout_data;
  logic [15:0] sat_cnt;
  logic        u1_din_ready, u1_dout_valid, u1_sat_flag;
  logic [7:0]  u1_dout_data;
  logic [1:0]  u1_sat_cnt;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          occ = 0;
  bit          rand_rdy = 0;
  int          s0, s1;

  localparam logic [15:0] VIN [9] = '{16'h0120, 16'h012F, 16'h07F0, 16'hF800, 16'h7FF0, 16'h8000, 16'h0FF0, 16'h1000, 16'hFF80};
  localparam logic [7:0]  E0  [9] = '{8'h12, 8'h12, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'hF8};
  localparam logic [7:0]  E1  [9] = '{8'h12, 8'h12, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  localparam int          C0  [9] = '{0, 0, 0, 0, 1, 2, 3, 4, 4};
  localparam int          C1  [9] = '{0, 0, 0, 1, 2, 3, 3, 3, 3};

  trunc_sat_pipe u0 (
    .clk(clk), .rst(rst), .din_ready(din_ready), .din_valid(din_valid), .din_data(din_data),
    .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_data(dout_data),
    .clr(clr), .sat_flag(sat_flag), .sat_cnt(sat_cnt)
  );
  trunc_sat_pipe #(.SIGNED(0), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .din_ready(u1_din_ready), .din_valid(din_valid), .din_data(din_data),
    .dout_ready(dout_ready), .dout_valid(u1_dout_valid), .dout_data(u1_dout_data),
    .clr(clr), .sat_flag(u1_sat_flag), .sat_cnt(u1_sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: bit 8 = saturated, bits 7:0 = result
  function automatic logic [8:0] model(input logic [15:0] d, input bit sgn);
    logic [11:0] kk;
    int k;
    kk = d[15:4];
    k = sgn ? int'($signed(kk)) : int'(kk);
    if (sgn && k > 127) return 9'h17F;
    if (sgn && k < -128) return 9'h180;
    if (!sgn && k > 255) return 9'h1FF;
    return {1'b0, k[7:0]};
  endfunction

  // present one word; returns at the negedge after it was accepted
  task automatic send(input logic [15:0] d, input logic [7:0] e0, input logic [7:0] e1);
    int n = 0;
    din_valid = 1;
    din_data = d;
    while (!din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: din_ready stuck 0 for word %h", d);
      din_valid = 0;
      return;
    end
    q0.push_back(e0);
    q1.push_back(e1);
    @(negedge clk);
    din_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (q0.size() != 0 || q1.size() != 0); n++) @(negedge clk);
    chk("drain_q0", 32'(q0.size()), 0);
    chk("drain_q1", 32'(q1.size()), 0);
  endtask

  initial forever begin
    @(negedge clk);
    if (rand_rdy) dout_ready = 1'($urandom_range(0, 1));
  end

  // monitor: occupancy model for handshakes, scoreboard pops on output transfers
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    #1;
    if (!rst) begin
      q0.delete();
      q1.delete();
      occ = 0;
    end else begin
      chk("u0_ready_vs_occ", 32'(din_ready), 32'(occ != 2));
      chk("u0_valid_vs_occ", 32'(dout_valid), 32'(occ != 0));
      chk("u1_ready_vs_occ", 32'(u1_din_ready), 32'(occ != 2));
      chk("u1_valid_vs_occ", 32'(u1_dout_valid), 32'(occ != 0));
      if (dout_valid && dout_ready) begin
        if (q0.size() == 0) chk("u0_unexpected_out", 32'(dout_data), 32'hFFFF_FFFF);
        else begin
          e = q0.pop_front();
          chk("u0_data", 32'(dout_data), 32'(e));
        end
      end
      if (u1_dout_valid && dout_ready) begin
        if (q1.size() == 0) chk("u1_unexpected_out", 32'(u1_dout_data), 32'hFFFF_FFFF);
        else begin
          e = q1.pop_front();
          chk("u1_data", 32'(u1_dout_data), 32'(e));
        end
      end
      occ += int'(din_valid && din_ready) - int'(dout_valid && dout_ready);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [8:0]  m0, m1;
    repeat (3) @(negedge clk);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_din_ready", 32'(din_ready), 1);
    chk("rst_dout_data", 32'(dout_data), 0);
    chk("rst_sat_flag", 32'(sat_flag), 0);
    chk("rst_sat_cnt", 32'(sat_cnt), 0);
    rst = 1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send(VIN[i], E0[i], E1[i]);
      if (i == 0) begin
        chk("latency_valid", 32'(dout_valid), 1);
        chk("latency_data", 32'(dout_data), 32'h12);
      end
      chk("dir_u0_cnt", 32'(sat_cnt), 32'(C0[i]));
      chk("dir_u0_flag", 32'(sat_flag), 32'(C0[i] != 0));
      chk("dir_u1_cnt", 32'(u1_sat_cnt), 32'(C1[i]));
      chk("dir_u1_flag", 32'(u1_sat_flag), 32'(C1[i] != 0));
    end
    drain();

    dout_ready = 0;
    fork
      begin
        send(16'h0010, 8'h01, 8'h01);
        send(16'h0020, 8'h02, 8'h02);
        send(16'h0030, 8'h03, 8'h03);
      end
      begin
        repeat (4) @(negedge clk);
        chk("bp_din_ready", 32'(din_ready), 0);
        chk("bp_head", 32'(dout_data), 32'h01);
        dout_ready = 1;
      end
    join
    drain();

    clr = 1;
    send(16'h7FF0, 8'h7F, 8'hFF);
    clr = 0;
    chk("clr_sat_u0_cnt", 32'(sat_cnt), 1);
    chk("clr_sat_u0_flag", 32'(sat_flag), 1);
    chk("clr_sat_u1_cnt", 32'(u1_sat_cnt), 1);
    clr = 1;
    send(16'h0120, 8'h12, 8'h12);
    clr = 0;
    chk("clr_nosat_u0_cnt", 32'(sat_cnt), 0);
    chk("clr_nosat_u0_flag", 32'(sat_flag), 0);
    chk("clr_nosat_u1_cnt", 32'(u1_sat_cnt), 0);
    drain();

    s0 = 0;
    s1 = 0;
    rand_rdy = 1;
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      m0 = model(d, 1);
      m1 = model(d, 0);
      s0 += int'(m0[8]);
      s1 += int'(m1[8]);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send(d, m0[7:0], m1[7:0]);
    end
    rand_rdy = 0;
    dout_ready = 1;
    drain();
    chk("rand_u0_cnt", 32'(sat_cnt), 32'(s0));
    chk("rand_u0_flag", 32'(sat_flag), 32'(s0 != 0));
    chk("rand_u1_cnt_hold", 32'(u1_sat_cnt), 32'(s1 > 3 ? 3 : s1));

    dout_ready = 0;
    send(16'h7FF0, 8'h7F, 8'hFF);
    send(16'h8000, 8'h80, 8'hFF);
    chk("two_din_ready", 32'(din_ready), 0);
    chk("two_dout_valid", 32'(dout_valid), 1);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("rst2_dout_valid", 32'(dout_valid), 0);
    chk("rst2_din_ready", 32'(din_ready), 1);
    chk("rst2_dout_data", 32'(dout_data), 0);
    chk("rst2_u0_cnt", 32'(sat_cnt), 0);
    chk("rst2_u0_flag", 32'(sat_flag), 0);
    chk("rst2_u1_cnt", 32'(u1_sat_cnt), 0);
    chk("rst2_u1_valid", 32'(u1_dout_valid), 0);
    dout_ready = 1;
    send(16'hFF80, 8'hF8, 8'hFF);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
